// File: rtl/frame_word_serializer.sv
// -----------------------------------------------------------------------------
// frame_word_serializer
//
// Captures words from the frame generator into a circular word store and
// drains them in address order onto a bipolar return-to-zero line pair.
// Each WORD_W-bit word goes out MSB first. Each bit cell is BIT_DIV clocks
// long. A '1' drives ser_p high for the first half of its cell. A '0' drives
// ser_n high for the first half of its cell. Each word is followed by
// GAP_BITS idle cells.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   wr_valid   one-cycle write strobe
//   wr_addr    store address of the write
//   wr_data    word to store
//   tx_en      transmit enable (level)
//   ser_p      positive line (first half of a '1' cell)
//   ser_n      negative line (first half of a '0' cell)
//   tx_busy    high while a word is loading, shifting or in its gap
//   word_done  one-cycle pulse on the last clock of the gap
//   level      words pending, 0..2**ADDR_W
//   ovf        sticky overflow flag (write while full)
//   par_err    parity error pulse; active only when PAR_CHECK_EN is defined
//
// Build option:
//   PAR_CHECK_EN  When defined, each loaded word is checked for odd parity.
//                 The marker word 0FFFF and the filler word 00000 are exempt.
//                 A failing word pulses par_err in the cycle after LOAD.
//                 When undefined, par_err is tied to 0.
// -----------------------------------------------------------------------------
module frame_word_serializer #(
  parameter int ADDR_W   = 8,
  parameter int WORD_W   = 18,
  parameter int BIT_DIV  = 16,
  parameter int GAP_BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              tx_en,
  output logic              ser_p,
  output logic              ser_n,
  output logic              tx_busy,
  output logic              word_done,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              par_err
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int HALF    = BIT_DIV / 2;
  localparam int GAP_LEN = GAP_BITS * BIT_DIV;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int BW      = $clog2(WORD_W);
  localparam int GW      = $clog2(GAP_LEN);
  localparam logic [ADDR_W:0] LVL_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] shreg;
  logic [ADDR_W-1:0] rd_ptr;
  logic              first_seen;
  logic [CW-1:0]     clk_cnt;
  logic [CW-1:0]     clk_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              is_load;

  assign is_load = (state == S_LOAD);
  assign rd_word = mem[rd_ptr];
  assign clk_nxt = clk_cnt + 1'b1;

  // Word store: data only, no reset. A LOAD in the same cycle as a write
  // to rd_ptr still sees the old word, because the write lands at the edge.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Occupancy, overflow and read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= '0;
      ovf        <= 1'b0;
      rd_ptr     <= '0;
      first_seen <= 1'b0;
    end else begin
      if (wr_valid && level == LVL_MAX) begin
        ovf <= 1'b1;
      end
      case ({wr_valid, is_load})
        2'b10: if (level != LVL_MAX) level <= level + 1'b1;
        2'b01: level <= level - 1'b1;
        default: ;  // no change, or write and load cancel
      endcase
      // The stream starts wherever the first write after reset lands
      if (wr_valid && !first_seen) begin
        rd_ptr     <= wr_addr;
        first_seen <= 1'b1;
      end else if (is_load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Transmit FSM. The line outputs are registered one step ahead, so each
  // branch sets the value the lines carry in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_p     <= 1'b0;
      ser_n     <= 1'b0;
      tx_busy   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ser_p     <= 1'b0;
          ser_n     <= 1'b0;
          word_done <= 1'b0;
          if (tx_en && level != '0) begin
            state   <= S_LOAD;
            tx_busy <= 1'b1;
          end
        end

        S_LOAD: begin
          shreg   <= rd_word;
          clk_cnt <= '0;
          bit_cnt <= '0;
          ser_p   <= rd_word[WORD_W-1];
          ser_n   <= ~rd_word[WORD_W-1];
          state   <= S_SHIFT;
        end

        S_SHIFT: begin
          if (clk_cnt == CW'(BIT_DIV-1)) begin
            clk_cnt <= '0;
            if (bit_cnt == BW'(WORD_W-1)) begin
              gap_cnt <= '0;
              ser_p   <= 1'b0;
              ser_n   <= 1'b0;
              state   <= S_GAP;
            end else begin
              // Rotate so the next bit sits at the MSB; its pulse starts now
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {shreg[WORD_W-2:0], shreg[WORD_W-1]};
              ser_p   <= shreg[WORD_W-2];
              ser_n   <= ~shreg[WORD_W-2];
            end
          end else begin
            clk_cnt <= clk_nxt;
            if (clk_nxt >= CW'(HALF)) begin
              ser_p <= 1'b0;
              ser_n <= 1'b0;
            end
          end
        end

        S_GAP: begin
          gap_cnt   <= gap_cnt + 1'b1;
          word_done <= (gap_cnt == GW'(GAP_LEN-2));
          if (gap_cnt == GW'(GAP_LEN-1)) begin
            word_done <= 1'b0;
            tx_busy   <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PAR_CHECK_EN
  localparam logic [WORD_W-1:0] MARKER = WORD_W'(18'h0FFFF);

  // Odd parity required; marker and all-zero filler are exempt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else begin
      par_err <= is_load && !(^rd_word) &&
                 (rd_word != MARKER) && (rd_word != '0);
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
